alu_ctrl_seq: RTL and testbench
===============================

Name: alu_ctrl_seq

Overview:
- Sequenced, parametrised successor to the combinational ALU operation decoder.
- Accepts one instruction per valid/ready handshake and registers the decoded ALU operation.
- Holds busy for a per-opcode latency (single- or multi-cycle), then pulses done with register-write and flag-write enables.
- Owns the architectural NZCV flag register. Sits between the main controller FSM and the ALU/register file.

Parameters:
- OPC_W, 3, opcode width; ALU operation width equals OPC_W; mask width is 2**OPC_W.
- FLAG_MASK, 8'b0110_1111, bit i=1: opcode i updates flags (ADD,SUB,RSB,AND,TST,CMP).
- ARITH_MASK, 8'b0100_0111, bit i=1: opcode i also updates C,V (ADD,SUB,RSB,CMP); others update N,Z only.
- WB_MASK, 8'b1001_1111, bit i=1: opcode i writes back a result (all except TST,CMP).
- MC_MASK, 8'b0000_0000, bit i=1: opcode i is multi-cycle.
- MC_LATENCY, 3, execute cycles for multi-cycle opcodes; must be ≥2.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_in  in  1  instruction present
- ready_out  out  1  block can accept (state IDLE)
- alu_op  in  2  mode: 00 force ADD, 01 force SUB, 1x decode opc
- opc  in  OPC_W  instruction opcode
- flush  in  1  synchronous abort of the current operation
- alu_n, alu_z, alu_c, alu_v  in  1 each  ALU result flags
- alu_operation  out  OPC_W  registered ALU operation select
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- reg_we  out  1  write-back enable, asserted only with done
- flag_we  out  1  flag update pulse, same edge that loads flags
- flags  out  4  {N,Z,C,V} architectural flags

Behaviour:
- Reset: async on rst_n low. State=IDLE, alu_operation=0, busy=0, done=0, reg_we=0, flag_we=0, flags=4'b0000, cnt=0; ready_out=1 once out of reset.
- States:
  - IDLE: ready_out=1.
  - EXEC: busy=1, ready_out=0.
- Accept: valid_in & ready_out & !flush at edge E0.
  - Latch the effective opcode: 0 if alu_op=00, 1 if alu_op=01, else opc.
  - alu_operation := effective opcode from E0 onward; held stable until the next accept.
  - Latency L = MC_LATENCY if MC_MASK[opc] and alu_op[1]=1, else 1. cnt := L-1. State goes to EXEC.
- EXEC:
  - cnt≠0: cnt decrements each edge.
  - cnt=0 at edge E0+L:
    - state→IDLE; done=1 for exactly one cycle.
    - reg_we=WB_MASK[opc] for decode mode, 1 for forced modes.
    - If flag update is enabled, flags load at E0+L and flag_we pulses in the same cycle as done.
- Flag update enable: decode mode and FLAG_MASK[opc]. Forced modes (00/01) never update flags.
  - N,Z always load from alu_n/alu_z.
  - C,V load from alu_c/alu_v only if ARITH_MASK[opc]; otherwise C,V are kept.
- Flags are sampled only at the completion edge. ALU flag inputs in other cycles are ignored.
- Throughput: at most one accept per L+1 cycles. valid_in in the done cycle is accepted, since the state is IDLE.
- flush:
  - In EXEC: state→IDLE next edge; no done, reg_we, flag_we or flag change. alu_operation is held.
  - In IDLE: blocks acceptance; flush wins over valid_in.
- flush on the completion edge: flush wins; the operation is discarded.
- rst_n low mid-operation: immediate return to reset values; the operation is lost.
- opc/alu_op changes while busy have no effect; all decoding uses latched values.
- Out-of-range mask bits do not occur: mask width = 2**OPC_W.

Test Plan:
- Reset: hold rst_n=0 → all outputs 0, flags=0000; release → ready_out=1, busy=0.
- ADD via decode: alu_op=10, opc=000, alu_{n,z,c,v}=0,0,1,1 at E1 → alu_operation=000 after E0; done, reg_we=1, flag_we=1 in cycle after E1; flags=0011.
- CMP then AND: CMP with flags 1,0,1,0 → flags=1010, reg_we=0. Then AND with ALU 0,1,1,1 → flags=0110 (C,V kept), reg_we=1.
- Forced mode: alu_op=01, opc=110 → alu_operation=001, reg_we=1, flag_we=0, flags unchanged.
- Multi-cycle: MC_MASK=8'h80, MC_LATENCY=3, MOV accepted at E0 → busy high for 3 cycles, done in cycle after E0+3, ready_out=0 throughout; a second valid_in during busy is not accepted.
- Flush: flush asserted at cnt=1 of a multi-cycle op → IDLE next edge, no done/flag_we, flags unchanged. flush with valid_in in IDLE → not accepted. rst_n pulse mid-op → outputs return to reset values.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: handshaked ALU operation sequencer with per-opcode latency and NZCV flag register.
module alu_ctrl_seq #(
    parameter int                  OPC_W      = 3,
    parameter logic [2**OPC_W-1:0] FLAG_MASK  = 8'b0110_1111,
    parameter logic [2**OPC_W-1:0] ARITH_MASK = 8'b0100_0111,
    parameter logic [2**OPC_W-1:0] WB_MASK    = 8'b1001_1111,
    parameter logic [2**OPC_W-1:0] MC_MASK    = 8'b0000_0000,
    parameter int                  MC_LATENCY = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [1:0]       alu_op,
    input  logic [OPC_W-1:0] opc,
    input  logic             flush,
    input  logic             alu_n,
    input  logic             alu_z,
    input  logic             alu_c,
    input  logic             alu_v,
    output logic [OPC_W-1:0] alu_operation,
    output logic             busy,
    output logic             done,
    output logic             reg_we,
    output logic             flag_we,
    output logic [3:0]       flags
);
    localparam int CW = $clog2(MC_LATENCY);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OPC_W-1:0] op_q, op_d;
    logic             dec_q, dec_d;
    logic             done_q, done_d, reg_we_q, reg_we_d, flag_we_q, flag_we_d;
    logic [3:0]       flags_q, flags_d;
    logic             accept, upd;

    assign ready_out     = rst_n && (state_q == IDLE);
    assign busy          = (state_q == EXEC);
    assign alu_operation = op_q;
    assign done          = done_q;
    assign reg_we        = reg_we_q;
    assign flag_we       = flag_we_q;
    assign flags         = flags_q;
    assign accept        = valid_in && ready_out && !flush;
    // masks are indexed by the latched opcode; forced modes never touch flags
    assign upd           = dec_q && FLAG_MASK[op_q];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        dec_d     = dec_q;
        done_d    = 1'b0;
        reg_we_d  = 1'b0;
        flag_we_d = 1'b0;
        flags_d   = flags_q;
        if (accept) begin
            state_d = EXEC;
            dec_d   = alu_op[1];
            op_d    = alu_op[1] ? opc : OPC_W'(alu_op[0]);
            cnt_d   = (alu_op[1] && MC_MASK[opc]) ? CW'(MC_LATENCY - 1) : '0;
        end
        if (state_q == EXEC) begin
            if (flush) begin
                state_d = IDLE;
            end else if (cnt_q != '0) begin
                cnt_d = cnt_q - CW'(1);
            end else begin
                state_d   = IDLE;
                done_d    = 1'b1;
                reg_we_d  = !dec_q || WB_MASK[op_q];
                flag_we_d = upd;
                if (upd) flags_d = {alu_n, alu_z, ARITH_MASK[op_q] ? {alu_c, alu_v} : flags_q[1:0]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            dec_q     <= 1'b0;
            done_q    <= 1'b0;
            reg_we_q  <= 1'b0;
            flag_we_q <= 1'b0;
            flags_q   <= 4'b0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            dec_q     <= dec_d;
            done_q    <= done_d;
            reg_we_q  <= reg_we_d;
            flag_we_q <= flag_we_d;
            flags_q   <= flags_d;
        end
    end
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed self-checking bench for alu_ctrl_seq (MOV configured multi-cycle).
module tb_alu_ctrl_seq;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_in = 1'b0, flush = 1'b0;
    logic       ready_out, busy, done, reg_we, flag_we;
    logic [1:0] alu_op = 2'b10;
    logic [2:0] opc = 3'b000, alu_operation;
    logic       alu_n = 1'b0, alu_z = 1'b0, alu_c = 1'b0, alu_v = 1'b0;
    logic [3:0] flags;
    int         tests = 0, fails = 0;

    alu_ctrl_seq #(.MC_MASK(8'h80), .MC_LATENCY(3)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_out(ready_out),
        .alu_op(alu_op), .opc(opc), .flush(flush),
        .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
        .alu_operation(alu_operation), .busy(busy), .done(done),
        .reg_we(reg_we), .flag_we(flag_we), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_alu(input logic [3:0] f);
        {alu_n, alu_z, alu_c, alu_v} = f;
    endtask

    task automatic issue(input logic [1:0] m, input logic [2:0] o);
        alu_op = m; opc = o; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tests++; if ({ready_out, busy, done, reg_we, flag_we} !== 5'b0) begin fails++; $display("FAIL reset_ctrl got %b want 00000", {ready_out, busy, done, reg_we, flag_we}); end
        tests++; if ({alu_operation, flags} !== 7'b0) begin fails++; $display("FAIL reset_data got op=%b flags=%b want 000/0000", alu_operation, flags); end
        rst_n = 1'b1;
        tick();
        tests++; if ({ready_out, busy} !== 2'b10) begin fails++; $display("FAIL reset_release got rdy/busy=%b want 10", {ready_out, busy}); end
    endtask

    task automatic test_add;
        set_alu(4'b1111);
        issue(2'b10, 3'b000);
        set_alu(4'b0011);
        tests++; if ({alu_operation, busy, ready_out, done} !== 6'b000_1_0_0) begin fails++; $display("FAIL add_exec got op=%b busy=%b rdy=%b done=%b want 000 1 0 0", alu_operation, busy, ready_out, done); end
        tick();
        tests++; if ({done, reg_we, flag_we, busy, ready_out} !== 5'b11101) begin fails++; $display("FAIL add_done got %b want 11101", {done, reg_we, flag_we, busy, ready_out}); end
        tests++; if (flags !== 4'b0011) begin fails++; $display("FAIL add_flags got %b want 0011", flags); end
        set_alu(4'b1100);
        tick();
        tests++; if ({done, reg_we, flag_we, flags} !== 7'b000_0011) begin fails++; $display("FAIL add_pulse got %b want 0000011", {done, reg_we, flag_we, flags}); end
    endtask

    task automatic test_cmp_and;
        issue(2'b10, 3'b110);
        set_alu(4'b1010);
        tick();
        tests++; if ({done, reg_we, flag_we, flags} !== 7'b101_1010) begin fails++; $display("FAIL cmp got %b want 1011010", {done, reg_we, flag_we, flags}); end
        issue(2'b10, 3'b011);
        set_alu(4'b0111);
        tick();
        tests++; if ({done, reg_we, flag_we, flags} !== 7'b111_0110) begin fails++; $display("FAIL and got %b want 1110110", {done, reg_we, flag_we, flags}); end
    endtask

    task automatic test_forced;
        issue(2'b01, 3'b110);
        set_alu(4'b1001);
        tests++; if (alu_operation !== 3'b001) begin fails++; $display("FAIL forced_op got %b want 001", alu_operation); end
        tick();
        tests++; if ({done, reg_we, flag_we, flags} !== 7'b110_0110) begin fails++; $display("FAIL forced_done got %b want 1100110", {done, reg_we, flag_we, flags}); end
    endtask

    task automatic test_multi;
        issue(2'b10, 3'b111);
        alu_op = 2'b10; opc = 3'b000; valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests++; if ({busy, ready_out, done} !== 3'b100) begin fails++; $display("FAIL multi_busy%0d got %b want 100", i, {busy, ready_out, done}); end
            if (i == 1) valid_in = 1'b0;
            if (i < 2) tick();
        end
        set_alu(4'b1111);
        tick();
        tests++; if ({done, reg_we, flag_we, busy, flags} !== 8'b1100_0110) begin fails++; $display("FAIL multi_done got %b want 11000110", {done, reg_we, flag_we, busy, flags}); end
        tests++; if (alu_operation !== 3'b111) begin fails++; $display("FAIL multi_op got %b want 111", alu_operation); end
    endtask

    task automatic test_back_to_back;
        issue(2'b00, 3'b101);
        alu_op = 2'b01; valid_in = 1'b1;
        tick();
        tests++; if ({done, reg_we, flag_we, alu_operation} !== 6'b110_000) begin fails++; $display("FAIL b2b_first got %b want 110000", {done, reg_we, flag_we, alu_operation}); end
        tick();
        valid_in = 1'b0;
        tests++; if ({busy, done, alu_operation} !== 5'b10_001) begin fails++; $display("FAIL b2b_second got %b want 10001", {busy, done, alu_operation}); end
        tick();
        tests++; if ({done, reg_we, busy} !== 3'b110) begin fails++; $display("FAIL b2b_done got %b want 110", {done, reg_we, busy}); end
        tick();
    endtask

    task automatic test_flush;
        issue(2'b10, 3'b111);
        tick();
        flush = 1'b1; set_alu(4'b1001);
        tick();
        flush = 1'b0;
        tests++; if ({busy, ready_out, done, flag_we, reg_we, flags} !== 9'b01000_0110) begin fails++; $display("FAIL flush_exec got %b want 010000110", {busy, ready_out, done, flag_we, reg_we, flags}); end
        tick();
        tests++; if ({done, busy, alu_operation} !== 5'b00_111) begin fails++; $display("FAIL flush_after got %b want 00111", {done, busy, alu_operation}); end
        flush = 1'b1;
        issue(2'b10, 3'b000);
        flush = 1'b0;
        tests++; if ({busy, alu_operation} !== 4'b0_111) begin fails++; $display("FAIL flush_idle got %b want 0111", {busy, alu_operation}); end
        issue(2'b10, 3'b000);
        rst_n = 1'b0;
        #1;
        tests++; if ({busy, ready_out, alu_operation, flags} !== 9'b0) begin fails++; $display("FAIL rst_mid got %b want 000000000", {busy, ready_out, alu_operation, flags}); end
        tick();
        rst_n = 1'b1;
        tick();
        tests++; if ({done, busy, ready_out} !== 3'b001) begin fails++; $display("FAIL rst_after got %b want 001", {done, busy, ready_out}); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_cmp_and();
        test_forced();
        test_multi();
        test_back_to_back();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
